id_queue_decode: RTL and testbench

- Next-generation RV32I decode stage with an instruction queue of FIFO_DEPTH entries between fetch and decode.
- Decodes the queue head, forwards operands from EX/MEM, and tracks in-flight loads with a countdown scoreboard instead of a single-cycle load-use check.
- Resolves JAL/JALR (and optionally branches) and issues into a registered output slot with a valid/ready handshake toward EX.

---
 rtl/id_queue_decode_if.sv | 49 ++++
 rtl/id_queue_decode.sv | 217 +++++++++++++++++++++
 tb/tb_id_queue_decode.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/id_queue_decode_if.sv
// Fetch, regfile, forwarding and issue signals of the id_queue_decode stage.
// master is the surrounding pipeline, slave is the decode stage.
interface id_queue_decode_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] in_pc;
   logic [31:0]     in_inst;
   logic            flush;
   logic [4:0]      rs1_addr;
   logic [4:0]      rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [4:0]      ex_rd_addr;
   logic            ex_rd_we;
   logic [XLEN-1:0] ex_rd_data;
   logic [4:0]      mem_rd_addr;
   logic            mem_rd_we;
   logic [XLEN-1:0] mem_rd_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [6:0]      out_opcode;
   logic [2:0]      out_funct3;
   logic            out_funct7b5;
   logic [XLEN-1:0] out_reg1;
   logic [XLEN-1:0] out_reg2;
   logic [XLEN-1:0] out_imm;
   logic [4:0]      out_rd;
   logic            out_rd_we;
   logic [XLEN-1:0] out_link;
   logic            jump_flag;
   logic [XLEN-1:0] jump_addr;

   modport master (
      output in_valid, in_pc, in_inst, flush, rs1_data, rs2_data,
             ex_rd_addr, ex_rd_we, ex_rd_data, mem_rd_addr, mem_rd_we, mem_rd_data, out_ready,
      input  in_ready, rs1_addr, rs2_addr, out_valid, out_pc, out_opcode, out_funct3,
             out_funct7b5, out_reg1, out_reg2, out_imm, out_rd, out_rd_we, out_link,
             jump_flag, jump_addr
   );

   modport slave (
      input  in_valid, in_pc, in_inst, flush, rs1_data, rs2_data,
             ex_rd_addr, ex_rd_we, ex_rd_data, mem_rd_addr, mem_rd_we, mem_rd_data, out_ready,
      output in_ready, rs1_addr, rs2_addr, out_valid, out_pc, out_opcode, out_funct3,
             out_funct7b5, out_reg1, out_reg2, out_imm, out_rd, out_rd_we, out_link,
             jump_flag, jump_addr
   );
endinterface

// File: rtl/id_queue_decode.sv
// RV32I decode stage: instruction queue, EX/MEM forwarding, load countdown scoreboard, JAL/JALR redirect.
// Define ID_BRANCH_RESOLVE_EN to also resolve conditional branches here.
module id_queue_decode #(
   parameter int XLEN       = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int LOAD_LAT   = 2
) (
   input  logic             clk,
   input  logic             rst,
   id_queue_decode_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
   } entry_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic            f7b5;
      logic [XLEN-1:0] reg1;
      logic [XLEN-1:0] reg2;
      logic [XLEN-1:0] imm;
      logic [4:0]      rd;
      logic            rd_we;
      logic [XLEN-1:0] link;
   } slot_t;

   entry_t          q [FIFO_DEPTH];
   logic [PW-1:0]   wptr, rptr;
   logic [PW:0]     count;
   logic [CW-1:0]   cnt [1:31];
   slot_t           slot, nxt;
   logic            vld, jflag;
   logic [XLEN-1:0] jaddr;

   entry_t          head;
   logic [6:0]      opc;
   logic [4:0]      rd, rs1, rs2;
   logic [2:0]      f3;
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm, op1, op2, tgt;
   logic            use1, use2, wr, is_load, take, hazard, push, issue, empty;

   assign head  = q[rptr];
   assign opc   = head.inst[6:0];
   assign rd    = head.inst[11:7];
   assign f3    = head.inst[14:12];
   assign rs1   = head.inst[19:15];
   assign rs2   = head.inst[24:20];
   assign imm   = XLEN'(signed'(imm32));
   assign empty = (count == '0);

   assign bus.in_ready = (count < (PW+1)'(FIFO_DEPTH));
   assign bus.rs1_addr = rs1;
   assign bus.rs2_addr = rs2;
   assign push  = bus.in_valid && bus.in_ready;
   assign issue = !empty && !bus.flush && (!vld || bus.out_ready) && !hazard;

   // x0 first, then the younger EX result, then MEM, then the regfile
   always_comb begin
      op1 = bus.rs1_data;
      if (rs1 == 5'd0) op1 = '0;
      else if (bus.ex_rd_we && bus.ex_rd_addr == rs1) op1 = bus.ex_rd_data;
      else if (bus.mem_rd_we && bus.mem_rd_addr == rs1) op1 = bus.mem_rd_data;
      op2 = bus.rs2_data;
      if (rs2 == 5'd0) op2 = '0;
      else if (bus.ex_rd_we && bus.ex_rd_addr == rs2) op2 = bus.ex_rd_data;
      else if (bus.mem_rd_we && bus.mem_rd_addr == rs2) op2 = bus.mem_rd_data;
   end

   always_comb begin
      imm32   = '0;
      use1    = 1'b0;
      use2    = 1'b0;
      wr      = 1'b0;
      is_load = 1'b0;
      take    = 1'b0;
      tgt     = '0;
      nxt        = '0;
      nxt.pc     = head.pc;
      nxt.opcode = opc;
      nxt.funct3 = f3;
      nxt.f7b5   = head.inst[30];
      nxt.rd     = rd;
      nxt.reg1   = op1;
      nxt.reg2   = op2;
      case (opc)
         OP_LUI:   begin imm32 = {head.inst[31:12], 12'b0}; wr = 1'b1; nxt.reg1 = '0; nxt.reg2 = imm; end
         OP_AUIPC: begin imm32 = {head.inst[31:12], 12'b0}; wr = 1'b1; nxt.reg1 = head.pc; nxt.reg2 = imm; end
         OP_JAL: begin
            imm32 = {{11{head.inst[31]}}, head.inst[31], head.inst[19:12], head.inst[20],
                     head.inst[30:21], 1'b0};
            wr = 1'b1; take = 1'b1; nxt.reg1 = head.pc;
            tgt = head.pc + imm;
            nxt.link = head.pc + XLEN'(4);
         end
         OP_JALR: begin
            imm32 = {{20{head.inst[31]}}, head.inst[31:20]};
            wr = 1'b1; use1 = 1'b1; take = 1'b1;
            tgt = (op1 + imm) & ~XLEN'(1);
            nxt.link = head.pc + XLEN'(4);
         end
         OP_BRANCH: begin
            imm32 = {{19{head.inst[31]}}, head.inst[31], head.inst[7], head.inst[30:25],
                     head.inst[11:8], 1'b0};
            use1 = 1'b1; use2 = 1'b1;
            tgt  = head.pc + imm;
`ifdef ID_BRANCH_RESOLVE_EN
            case (f3)
               3'b000:  take = (op1 == op2);
               3'b001:  take = (op1 != op2);
               3'b100:  take = ($signed(op1) <  $signed(op2));
               3'b101:  take = ($signed(op1) >= $signed(op2));
               3'b110:  take = (op1 <  op2);
               3'b111:  take = (op1 >= op2);
               default: take = 1'b0;
            endcase
`endif
         end
         OP_LOAD:  begin imm32 = {{20{head.inst[31]}}, head.inst[31:20]}; wr = 1'b1; use1 = 1'b1; is_load = 1'b1; nxt.reg2 = imm; end
         OP_STORE: begin imm32 = {{20{head.inst[31]}}, head.inst[31:25], head.inst[11:7]}; use1 = 1'b1; use2 = 1'b1; end
         OP_IMM:   begin imm32 = {{20{head.inst[31]}}, head.inst[31:20]}; wr = 1'b1; use1 = 1'b1; nxt.reg2 = imm; end
         OP_REG:   begin wr = 1'b1; use1 = 1'b1; use2 = 1'b1; end
         default:  ;
      endcase
      nxt.imm   = imm;
      nxt.rd_we = wr && (rd != 5'd0);
   end

   always_comb begin
      hazard = 1'b0;
      for (int i = 1; i < 32; i++)
         if (((use1 && rs1 == 5'(i)) || (use2 && rs2 == 5'(i))) && cnt[i] != '0) hazard = 1'b1;
   end

   for (genvar r = 1; r < 32; r++) begin : g_sb
      // a new load to the same rd restarts the countdown
      always_ff @(posedge clk) begin
         if (rst) cnt[r] <= '0;
         else if (issue && is_load && rd == 5'(r)) cnt[r] <= CW'(LOAD_LAT);
         else if (cnt[r] != '0) cnt[r] <= cnt[r] - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (bus.flush || (issue && take)) begin
         // younger instructions behind a redirect are wrong-path, drop them and any push
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push)  wptr <= wptr + PW'(1);
         if (issue) rptr <= rptr + PW'(1);
         count <= count + (PW+1)'(push) - (PW+1)'(issue);
      end
   end

   always_ff @(posedge clk) begin
      if (push) q[wptr] <= '{pc: bus.in_pc, inst: bus.in_inst};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld   <= 1'b0;
         jflag <= 1'b0;
         jaddr <= '0;
         slot  <= '0;
      end else begin
         jflag <= 1'b0;
         if (bus.flush) begin
            vld <= 1'b0;
         end else if (issue) begin
            vld  <= 1'b1;
            slot <= nxt;
            if (take) begin
               jflag <= 1'b1;
               jaddr <= tgt;
            end
         end else if (bus.out_ready) begin
            vld <= 1'b0;
         end
      end
   end

   assign bus.out_valid    = vld;
   assign bus.out_pc       = slot.pc;
   assign bus.out_opcode   = slot.opcode;
   assign bus.out_funct3   = slot.funct3;
   assign bus.out_funct7b5 = slot.f7b5;
   assign bus.out_reg1     = slot.reg1;
   assign bus.out_reg2     = slot.reg2;
   assign bus.out_imm      = slot.imm;
   assign bus.out_rd       = slot.rd;
   assign bus.out_rd_we    = slot.rd_we;
   assign bus.out_link     = slot.link;
   assign bus.jump_flag    = jflag;
   assign bus.jump_addr    = jaddr;
endmodule

// File: tb/tb_id_queue_decode.sv
// Directed bench for id_queue_decode: queue fill/drain, load stall, forwarding, jumps, flush, reset.
module tb_id_queue_decode;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   id_queue_decode_if #(.XLEN(32)) bus ();
   id_queue_decode dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] inst);
      bus.in_valid = 1'b1;
      bus.in_pc    = pc;
      bus.in_inst  = inst;
      tick();
   endtask

   function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] s1,
                                         input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
      return {im, s1, f3, d, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] s2, input logic [4:0] s1, input logic [4:0] d);
      return {7'b0, s2, s1, 3'b000, d, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] d);
      return {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] s2,
                                         input logic [4:0] s1, input logic [2:0] f3);
      return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'b1100011};
   endfunction

   logic [31:0] nop;
   logic        br_taken;

   initial begin
      nop = enc_i(12'd0, 5'd0, 3'd0, 5'd0, 7'b0010011);
      bus.in_valid = 0; bus.in_pc = 0; bus.in_inst = 0; bus.flush = 0;
      bus.rs1_data = 32'h99; bus.rs2_data = 32'h7;
      bus.ex_rd_addr = 0; bus.ex_rd_we = 0; bus.ex_rd_data = 0;
      bus.mem_rd_addr = 0; bus.mem_rd_we = 0; bus.mem_rd_data = 0;
      bus.out_ready = 0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_jump_flag", 32'(bus.jump_flag), 32'd0);
      check("rst_out_pc", bus.out_pc, 32'd0);

      // fill: first instruction lands in the slot, next four fill the queue
      for (int i = 0; i < 5; i++)
         push(32'(4 * i), enc_i(12'(i), 5'd0, 3'd0, 5'(i + 1), 7'b0010011));
      check("fill_in_ready", 32'(bus.in_ready), 32'd0);
      check("fill_out_valid", 32'(bus.out_valid), 32'd1);
      check("fill_out_pc", bus.out_pc, 32'h0);
      push(32'h14, enc_i(12'd5, 5'd0, 3'd0, 5'd6, 7'b0010011));
      check("held_in_ready", 32'(bus.in_ready), 32'd0);
      check("held_out_pc", bus.out_pc, 32'h0);
      bus.out_ready = 1'b1;
      tick();
      check("drain_pc1", bus.out_pc, 32'h4);
      check("drain_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      check("drain_pc2", bus.out_pc, 32'h8);
      tick(); check("drain_pc3", bus.out_pc, 32'hc);
      tick(); check("drain_pc4", bus.out_pc, 32'h10);
      tick(); check("drain_pc5", bus.out_pc, 32'h14);
      check("drain_reg2", bus.out_reg2, 32'd5);
      check("drain_rd", 32'(bus.out_rd), 32'd6);
      tick();
      check("drain_done", 32'(bus.out_valid), 32'd0);

      // load-use: LW x5,8(x1) then ADD x6,x5,x7
      push(32'h20, enc_i(12'd8, 5'd1, 3'b010, 5'd5, 7'b0000011));
      push(32'h24, enc_r(5'd7, 5'd5, 5'd6));
      bus.in_valid = 1'b0;
      check("lw_pc", bus.out_pc, 32'h20);
      check("lw_reg1", bus.out_reg1, 32'h99);
      check("lw_reg2", bus.out_reg2, 32'h8);
      tick(); check("lw_stall1", 32'(bus.out_valid), 32'd0);
      tick(); check("lw_stall2", 32'(bus.out_valid), 32'd0);
      bus.mem_rd_addr = 5'd5; bus.mem_rd_we = 1'b1; bus.mem_rd_data = 32'h1234;
      tick();
      check("add_valid", 32'(bus.out_valid), 32'd1);
      check("add_pc", bus.out_pc, 32'h24);
      check("add_reg1", bus.out_reg1, 32'h1234);
      check("add_reg2", bus.out_reg2, 32'h7);

      // forwarding priority
      bus.ex_rd_addr = 5'd3; bus.ex_rd_we = 1'b1; bus.ex_rd_data = 32'hA;
      bus.mem_rd_addr = 5'd3; bus.mem_rd_data = 32'hB;
      push(32'h50, enc_r(5'd0, 5'd3, 5'd4));
      bus.in_valid = 1'b0; tick();
      check("fwd_ex_reg1", bus.out_reg1, 32'hA);
      check("fwd_x0_reg2", bus.out_reg2, 32'h0);
      bus.ex_rd_addr = 5'd9;
      push(32'h54, enc_r(5'd0, 5'd3, 5'd4));
      bus.in_valid = 1'b0; tick();
      check("fwd_mem_reg1", bus.out_reg1, 32'hB);
      bus.ex_rd_addr = 5'd0; bus.ex_rd_data = 32'hDEAD;
      push(32'h58, enc_r(5'd3, 5'd0, 5'd4));
      bus.in_valid = 1'b0; tick();
      check("fwd_x0_reg1", bus.out_reg1, 32'h0);
      check("fwd_mem_reg2", bus.out_reg2, 32'hB);
      bus.ex_rd_we = 1'b0; bus.mem_rd_we = 1'b0;
      tick();

      // JAL x1,+16 with three younger instructions queued
      bus.out_ready = 1'b0;
      push(32'hF0, nop);
      push(32'h100, enc_j(21'd16, 5'd1));
      push(32'h104, nop);
      push(32'h108, nop);
      push(32'h10c, nop);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check("jal_flag", 32'(bus.jump_flag), 32'd1);
      check("jal_addr", bus.jump_addr, 32'h110);
      check("jal_link", bus.out_link, 32'h104);
      check("jal_pc", bus.out_pc, 32'h100);
      check("jal_reg1", bus.out_reg1, 32'h100);
      tick();
      check("jal_pulse", 32'(bus.jump_flag), 32'd0);
      check("jal_discard", 32'(bus.out_valid), 32'd0);
      check("jal_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      check("jal_empty", 32'(bus.out_valid), 32'd0);

      // JALR x0,5(x2) with x2=0x200
      bus.rs1_data = 32'h200;
      push(32'h300, enc_i(12'd5, 5'd2, 3'd0, 5'd0, 7'b1100111));
      bus.in_valid = 1'b0; tick();
      check("jalr_flag", 32'(bus.jump_flag), 32'd1);
      check("jalr_addr", bus.jump_addr, 32'h204);
      check("jalr_link", bus.out_link, 32'h304);
      check("jalr_rd_we", 32'(bus.out_rd_we), 32'd0);
      tick();
      bus.rs1_data = 32'h99;

      // flush during an output stall, with a push on the flush edge
      bus.out_ready = 1'b0;
      push(32'h400, nop);
      push(32'h404, nop);
      push(32'h408, nop);
      check("pre_flush_valid", 32'(bus.out_valid), 32'd1);
      bus.flush = 1'b1;
      push(32'h40c, nop);
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      check("flush_valid", 32'(bus.out_valid), 32'd0);
      check("flush_in_ready", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b1;
      tick(); tick();
      check("flush_empty", 32'(bus.out_valid), 32'd0);

      // BLT x1,x2,-8 with x1=-1 (EX), x2=1 (MEM)
      bus.ex_rd_addr = 5'd1; bus.ex_rd_we = 1'b1; bus.ex_rd_data = 32'hFFFF_FFFF;
      bus.mem_rd_addr = 5'd2; bus.mem_rd_we = 1'b1; bus.mem_rd_data = 32'h1;
      push(32'h40, enc_b(13'h1FF8, 5'd2, 5'd1, 3'b100));
      bus.in_valid = 1'b0; tick();
`ifdef ID_BRANCH_RESOLVE_EN
      br_taken = 1'b1;
      check("blt_addr", bus.jump_addr, 32'h38);
`else
      br_taken = 1'b0;
`endif
      check("blt_flag", 32'(bus.jump_flag), 32'(br_taken));
      check("blt_valid", 32'(bus.out_valid), 32'd1);
      check("blt_imm", bus.out_imm, 32'hFFFF_FFF8);
      check("blt_rd_we", 32'(bus.out_rd_we), 32'd0);
      bus.ex_rd_we = 1'b0; bus.mem_rd_we = 1'b0;
      tick();

      // unknown opcode issues as a non-writing op
      push(32'h60, 32'hFFFF_FFFF);
      bus.in_valid = 1'b0; tick();
      check("unk_valid", 32'(bus.out_valid), 32'd1);
      check("unk_opcode", 32'(bus.out_opcode), 32'h7F);
      check("unk_rd_we", 32'(bus.out_rd_we), 32'd0);
      tick();

      // reset in the middle of a stall
      bus.out_ready = 1'b0;
      push(32'h80, nop);
      push(32'h84, nop);
      rst = 1'b1;
      push(32'h88, nop);
      rst = 1'b0; bus.in_valid = 1'b0;
      check("mrst_valid", 32'(bus.out_valid), 32'd0);
      check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
      check("mrst_out_pc", bus.out_pc, 32'd0);
      bus.out_ready = 1'b1;
      tick(); tick();
      check("mrst_empty", 32'(bus.out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
